// File: rtl/data_store_fifo_pkg.sv
// rtl/data_store_fifo_pkg.sv - store size codes and entry layout shared by execute, commit and the store FIFO
package data_store_fifo_pkg;

    // Store size codes as produced by execute and carried through commit.
    // Code 3 is not generated by the pipeline and is treated as a full word.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // One buffered store, already lane-encoded so the head can drive the
    // memory port directly without any logic behind the storage array.
    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } store_entry_t;

    // Word index of a byte address; loads and stores are compared on this.
    function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/data_store_fifo_store_lane_encode.sv
// rtl/data_store_fifo_store_lane_encode.sv - byte-lane strobe and data replication for one store
import data_store_fifo_pkg::*;

module store_lane_encode (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] val,
    output logic [3:0]  strb,
    output logic [31:0] data
);

    // Select the lanes touched by the store and copy the value onto every
    // lane so memory can pick whichever lane the strobes enable.
    always_comb begin
        strb = 4'b1111;
        data = val;
        case (size)
            SIZE_BYTE: begin
                strb = 4'b0001 << addr_lo;
                data = {4{val[7:0]}};
            end
            SIZE_HALF: begin
                // addr_lo[0] is ignored: halfwords land on lanes 0-1 or 2-3.
                strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                data = {2{val[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                data = val;
            end
        endcase
    end

endmodule

// File: rtl/data_store_fifo.sv
// rtl/data_store_fifo.sv - in-order committed store buffer with load-address hazard detection
import data_store_fifo_pkg::*;

module data_store_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] datafifo_addr_in,
    input  logic [31:0] datafifo_val_in,
    input  logic [1:0]  datafifo_size_in,
    input  logic        datafifo_valid_in,
    output logic        datafifo_full,
    output logic [31:0] mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_strb,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    input  logic [31:0] query_addr,
    output logic        query_hit,
    output logic        empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    store_entry_t entries_q [DEPTH];
    store_entry_t entries_d [DEPTH];

    store_entry_t new_entry;
    store_entry_t head_entry;
    logic [3:0]   enc_strb;
    logic [31:0]  enc_data;

    logic push;
    logic pop;

    logic [PTR_W-1:0] slot_off;

    store_lane_encode u_lane_encode (
        .addr_lo (datafifo_addr_in[1:0]),
        .size    (datafifo_size_in),
        .val     (datafifo_val_in),
        .strb    (enc_strb),
        .data    (enc_data)
    );

    // Status flags come only from the registered count, so a push never
    // falls through to the memory port in the same cycle.
    always_comb begin
        datafifo_full = (count_q == CNT_FULL);
        empty         = (count_q == '0);
        mem_wr_valid  = !empty;
        push          = datafifo_valid_in && !datafifo_full;
        pop           = mem_wr_valid && mem_wr_ready;
    end

    // Pack the incoming store and present the head entry to memory.
    always_comb begin
        new_entry.word_addr = word_of(datafifo_addr_in);
        new_entry.data      = enc_data;
        new_entry.strb      = enc_strb;
        head_entry          = entries_q[rd_ptr_q];
        mem_wr_addr         = {head_entry.word_addr, 2'b00};
        mem_wr_data         = head_entry.data;
        mem_wr_strb         = head_entry.strb;
    end

    // Pointer and occupancy updates; a full FIFO only frees its slot for the
    // following cycle because push is already blocked by the full flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage write: only the slot under the write pointer changes.
    always_comb begin
        entries_d = entries_q;
        if (push && !reset) begin
            entries_d[wr_ptr_q] = new_entry;
        end
    end

    // A load must wait if any pending store, or the store entering this
    // cycle, targets the same word. Byte lanes are deliberately ignored.
    always_comb begin
        query_hit = 1'b0;
        slot_off  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < count_q) &&
                (entries_q[i].word_addr == word_of(query_addr))) begin
                query_hit = 1'b1;
            end
        end
        if (push && (word_of(datafifo_addr_in) == word_of(query_addr))) begin
            query_hit = 1'b1;
        end
    end

    // Control state register; reset drops every pending store.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array register; contents are meaningless until occupied.
    always_ff @(posedge clk) begin
        entries_q <= entries_d;
    end

endmodule

// File: tb/tb_data_store_fifo.sv
// tb/tb_data_store_fifo.sv - directed self-checking bench for the store FIFO
module tb_data_store_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] datafifo_addr_in;
    logic [31:0] datafifo_val_in;
    logic [1:0]  datafifo_size_in;
    logic        datafifo_valid_in;
    logic        datafifo_full;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        mem_wr_valid;
    logic        mem_wr_ready;
    logic [31:0] query_addr;
    logic        query_hit;
    logic        empty;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    wr_t wr_log[$];

    data_store_fifo #(.DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .datafifo_addr_in  (datafifo_addr_in),
        .datafifo_val_in   (datafifo_val_in),
        .datafifo_size_in  (datafifo_size_in),
        .datafifo_valid_in (datafifo_valid_in),
        .datafifo_full     (datafifo_full),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_strb       (mem_wr_strb),
        .mem_wr_valid      (mem_wr_valid),
        .mem_wr_ready      (mem_wr_ready),
        .query_addr        (query_addr),
        .query_hit         (query_hit),
        .empty             (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_valid === 1'b1 && mem_wr_ready === 1'b1) begin
            wr_log.push_back('{a: mem_wr_addr, d: mem_wr_data, s: mem_wr_strb});
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        datafifo_addr_in  = a;
        datafifo_val_in   = v;
        datafifo_size_in  = s;
        datafifo_valid_in = 1'b1;
        step();
        datafifo_valid_in = 1'b0;
    endtask

    task automatic drain(input int budget);
        mem_wr_ready = 1'b1;
        for (int k = 0; k < budget && empty !== 1'b1; k++) step();
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (datafifo_full !== 1'b0) $display("FAIL reset_full got %b want 0", datafifo_full); else n_pass++;
        n_checks++; if (mem_wr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", mem_wr_valid); else n_pass++;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL reset_hit got %b want 0", query_hit); else n_pass++;
    endtask

    task automatic test_word();
        mem_wr_ready      = 1'b1;
        datafifo_addr_in  = 32'h0000_1000;
        datafifo_val_in   = 32'hDEAD_BEEF;
        datafifo_size_in  = 2'd2;
        datafifo_valid_in = 1'b1;
        n_checks++; if (mem_wr_valid !== 1'b0) $display("FAIL word_no_fallthrough got %b want 0", mem_wr_valid); else n_pass++;
        step();
        datafifo_valid_in = 1'b0;
        n_checks++; if (mem_wr_valid !== 1'b1) $display("FAIL word_valid got %b want 1", mem_wr_valid); else n_pass++;
        n_checks++; if (mem_wr_addr !== 32'h0000_1000) $display("FAIL word_addr got %h want 00001000", mem_wr_addr); else n_pass++;
        n_checks++; if (mem_wr_strb !== 4'b1111) $display("FAIL word_strb got %b want 1111", mem_wr_strb); else n_pass++;
        n_checks++; if (mem_wr_data !== 32'hDEAD_BEEF) $display("FAIL word_data got %h want deadbeef", mem_wr_data); else n_pass++;
        step();
        n_checks++; if (empty !== 1'b1) $display("FAIL word_empty_after got %b want 1", empty); else n_pass++;
        mem_wr_ready = 1'b0;
    endtask

    task automatic test_lanes();
        push(32'h0000_2003, 32'h1234_56A5, 2'd0);
        push(32'h0000_2006, 32'hABCD_1234, 2'd1);
        n_checks++; if (mem_wr_strb !== 4'b1000) $display("FAIL byte_strb got %b want 1000", mem_wr_strb); else n_pass++;
        n_checks++; if (mem_wr_data !== 32'hA5A5_A5A5) $display("FAIL byte_data got %h want a5a5a5a5", mem_wr_data); else n_pass++;
        n_checks++; if (mem_wr_addr !== 32'h0000_2000) $display("FAIL byte_addr got %h want 00002000", mem_wr_addr); else n_pass++;
        mem_wr_ready = 1'b1;
        step();
        mem_wr_ready = 1'b0;
        n_checks++; if (mem_wr_strb !== 4'b1100) $display("FAIL half_strb got %b want 1100", mem_wr_strb); else n_pass++;
        n_checks++; if (mem_wr_data !== 32'h1234_1234) $display("FAIL half_data got %h want 12341234", mem_wr_data); else n_pass++;
        n_checks++; if (mem_wr_addr !== 32'h0000_2004) $display("FAIL half_addr got %h want 00002004", mem_wr_addr); else n_pass++;
        drain(8);
        n_checks++; if (empty !== 1'b1) $display("FAIL lanes_drain got %b want 1", empty); else n_pass++;
    endtask

    task automatic test_full();
        wr_log.delete();
        for (int i = 0; i < 4; i++) push(32'h0000_4000 + 32'(i * 4), 32'(i + 1), 2'd2);
        n_checks++; if (datafifo_full !== 1'b1) $display("FAIL full_set got %b want 1", datafifo_full); else n_pass++;
        push(32'h0000_4010, 32'h0000_0055, 2'd2);
        n_checks++; if (datafifo_full !== 1'b1) $display("FAIL full_hold got %b want 1", datafifo_full); else n_pass++;
        n_checks++; if (mem_wr_addr !== 32'h0000_4000) $display("FAIL full_head got %h want 00004000", mem_wr_addr); else n_pass++;
        mem_wr_ready = 1'b1;
        step();
        n_checks++; if (datafifo_full !== 1'b0) $display("FAIL full_drop got %b want 0", datafifo_full); else n_pass++;
        drain(10);
        n_checks++; if (empty !== 1'b1) $display("FAIL full_drain got %b want 1", empty); else n_pass++;
        n_checks++; if (wr_log.size() !== 4) $display("FAIL full_write_count got %0d want 4", wr_log.size()); else n_pass++;
        for (int i = 0; i < 4 && i < wr_log.size(); i++) begin
            n_checks++;
            if (wr_log[i].a !== 32'h0000_4000 + 32'(i * 4) || wr_log[i].d !== 32'(i + 1))
                $display("FAIL full_order[%0d] got %h/%h want %h/%h", i, wr_log[i].a, wr_log[i].d,
                         32'h0000_4000 + 32'(i * 4), 32'(i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_full_push_pop();
        wr_log.delete();
        for (int i = 0; i < 4; i++) push(32'h0000_5000 + 32'(i * 4), 32'h100 + 32'(i), 2'd2);
        datafifo_addr_in  = 32'h0000_5040;
        datafifo_val_in   = 32'h0000_0BAD;
        datafifo_size_in  = 2'd2;
        datafifo_valid_in = 1'b1;
        mem_wr_ready      = 1'b1;
        step();
        datafifo_valid_in = 1'b0;
        mem_wr_ready      = 1'b0;
        n_checks++; if (datafifo_full !== 1'b0) $display("FAIL pp_not_full got %b want 0", datafifo_full); else n_pass++;
        n_checks++; if (mem_wr_addr !== 32'h0000_5004) $display("FAIL pp_head got %h want 00005004", mem_wr_addr); else n_pass++;
        drain(10);
        n_checks++; if (wr_log.size() !== 4) $display("FAIL pp_write_count got %0d want 4", wr_log.size()); else n_pass++;
        if (wr_log.size() == 4) begin
            n_checks++; if (wr_log[3].a !== 32'h0000_500C) $display("FAIL pp_last_addr got %h want 0000500c", wr_log[3].a); else n_pass++;
        end
    endtask

    task automatic test_query();
        push(32'h0000_3004, 32'h0000_0077, 2'd2);
        query_addr = 32'h0000_3006;
        #1;
        n_checks++; if (query_hit !== 1'b1) $display("FAIL query_same_word got %b want 1", query_hit); else n_pass++;
        query_addr = 32'h0000_3008;
        #1;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL query_other_word got %b want 0", query_hit); else n_pass++;
        datafifo_addr_in  = 32'h0000_3008;
        datafifo_val_in   = 32'h0;
        datafifo_size_in  = 2'd0;
        datafifo_valid_in = 1'b1;
        #1;
        n_checks++; if (query_hit !== 1'b1) $display("FAIL query_push_bypass got %b want 1", query_hit); else n_pass++;
        datafifo_valid_in = 1'b0;
        #1;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL query_push_gone got %b want 0", query_hit); else n_pass++;
        drain(8);
        query_addr = 32'h0000_3004;
        #1;
        n_checks++; if (query_hit !== 1'b0) $display("FAIL query_after_drain got %b want 0", query_hit); else n_pass++;
        query_addr = 32'h0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) push(32'h0000_6000 + 32'(i * 4), 32'(i), 2'd2);
        wr_log.delete();
        reset             = 1'b1;
        datafifo_addr_in  = 32'h0000_6100;
        datafifo_valid_in = 1'b1;
        step();
        reset             = 1'b0;
        datafifo_valid_in = 1'b0;
        n_checks++; if (empty !== 1'b1) $display("FAIL rst_mid_empty got %b want 1", empty); else n_pass++;
        n_checks++; if (mem_wr_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", mem_wr_valid); else n_pass++;
        mem_wr_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        mem_wr_ready = 1'b0;
        n_checks++; if (wr_log.size() !== 0) $display("FAIL rst_mid_writes got %0d want 0", wr_log.size()); else n_pass++;
    endtask

    initial begin
        reset             = 1'b1;
        datafifo_addr_in  = '0;
        datafifo_val_in   = '0;
        datafifo_size_in  = '0;
        datafifo_valid_in = 1'b0;
        mem_wr_ready      = 1'b0;
        query_addr        = '0;
        @(negedge clk);
        test_reset();
        test_word();
        test_lanes();
        test_full();
        test_full_push_pop();
        test_query();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
